// File: rtl/regx_bank_if.sv
// Bus/handshake bundle between the load sequencer (master) and the operand
// staging bank (slave).
interface regx_bank_if #(
  parameter int DW   = 4,
  parameter int NOPS = 2,
  parameter int OPW  = 4,
  parameter int SW   = $clog2(NOPS + 1)
);
  logic                 ld;
  logic [SW-1:0]        ld_sel;
  logic [DW-1:0]        bus_in;
  logic [NOPS*DW-1:0]   ops;
  logic [OPW-1:0]       opcode;
  logic [NOPS:0]        ld_mask;
  logic                 issue_valid;
  logic                 issue_ready;
  logic                 ld_err;

  modport master (
    output ld, ld_sel, bus_in, issue_ready,
    input  ops, opcode, ld_mask, issue_valid, ld_err
  );

  modport slave (
    input  ld, ld_sel, bus_in, issue_ready,
    output ops, opcode, ld_mask, issue_valid, ld_err
  );
endinterface

// File: rtl/regx_bank.sv
// ALU operand staging bank: collects NOPS operands plus an opcode from the
// data bus and offers the complete set to the ALU over valid/ready.
module regx_bank #(
  parameter int DW   = 4,
  parameter int NOPS = 2,
  parameter int OPW  = 4,
  parameter int AUTO = 0,
  parameter int SW   = $clog2(NOPS + 1)
) (
  input  logic        clk,
  input  logic        grst_n,
  input  logic        lrst,
  regx_bank_if.slave  bus
);

  typedef enum logic {COLLECT = 1'b0, READY = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [NOPS*DW-1:0]   ops_q, ops_d;
  logic [OPW-1:0]       opc_q, opc_d;
  logic [NOPS:0]        mask_q, mask_d, mask_base;
  logic [SW-1:0]        ptr_q, ptr_d, tgt;
  logic                 err_q, err_d;
  logic                 sel_ok, hs, accept;

  always_comb begin
    tgt    = (AUTO != 0) ? ptr_q : bus.ld_sel;
    sel_ok = (AUTO != 0) || (bus.ld_sel <= SW'(NOPS));
    hs     = (state_q == READY) && bus.issue_ready;
    // A load during READY is only legal on the handshake edge, where it
    // becomes the first load of the next set.
    accept = bus.ld && sel_ok && ((state_q == COLLECT) || hs);
  end

  always_comb begin
    mask_base = hs ? '0 : mask_q;
    mask_d    = mask_base;
    ops_d     = ops_q;
    opc_d     = opc_q;
    for (int k = 0; k < NOPS; k++) begin
      if (accept && (tgt == SW'(k))) begin
        ops_d[k*DW +: DW] = bus.bus_in;
        mask_d[k]         = 1'b1;
      end
    end
    if (accept && (tgt == SW'(NOPS))) begin
      opc_d        = bus.bus_in[OPW-1:0];
      mask_d[NOPS] = 1'b1;
    end
    ptr_d = ptr_q;
    if ((AUTO != 0) && accept)
      ptr_d = (ptr_q == SW'(NOPS)) ? '0 : ptr_q + SW'(1);
    err_d = bus.ld && !accept;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (accept && (&mask_d)) state_d = READY;
      READY:   if (hs) state_d = (&mask_d) ? READY : COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge grst_n) begin
    if (!grst_n)   state_q <= COLLECT;
    else if (lrst) state_q <= COLLECT;
    else           state_q <= state_d;
  end

  always_ff @(posedge clk or negedge grst_n) begin
    if (!grst_n) begin
      ops_q  <= '0;
      opc_q  <= '0;
      mask_q <= '0;
      ptr_q  <= '0;
      err_q  <= 1'b0;
    end else if (lrst) begin
      ops_q  <= '0;
      opc_q  <= '0;
      mask_q <= '0;
      ptr_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      ops_q  <= ops_d;
      opc_q  <= opc_d;
      mask_q <= mask_d;
      ptr_q  <= ptr_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    bus.ops         = ops_q;
    bus.opcode      = opc_q;
    bus.ld_mask     = mask_q;
    bus.issue_valid = (state_q == READY);
    bus.ld_err      = err_q;
  end

endmodule
